// File: rtl/vector_writeback_buffer.sv
// In-order {addr, data} FIFO between the vector result producer and register-file
// write port 3, with a per-register pending scoreboard for hazard detection.
module vector_writeback_buffer #(
  parameter int NUM_REGS  = 8,
  parameter int REG_WIDTH = 256,
  parameter int DEPTH     = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [4:0]               in_addr,
  input  logic [REG_WIDTH-1:0]     in_data,
  input  logic                     wb_stall,
  output logic                     WE3,
  output logic [4:0]               A3,
  output logic [REG_WIDTH-1:0]     WD3,
  output logic [NUM_REGS-1:0]      pending,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     drop_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0]        rd_ptr;
  logic [AW-1:0]        wr_ptr;
  logic [4:0]           addr_mem [DEPTH];
  logic [REG_WIDTH-1:0] data_mem [DEPTH];
  logic                 accept;
  logic                 in_range;
  logic                 push;
  logic                 pop;

  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));
  assign in_ready = !full;
  assign in_range = ({27'd0, in_addr} < 32'(NUM_REGS));
  assign accept   = in_valid && in_ready;
  assign push     = accept && in_range;
  assign WE3      = !empty && !wb_stall;
  assign pop      = WE3;
  assign A3       = empty ? '0 : addr_mem[rd_ptr];
  assign WD3      = empty ? '0 : data_mem[rd_ptr];

  // Scan from the head: the entry i slots past rd_ptr is live iff i < count.
  always_comb begin
    pending = '0;
    for (int i = 0; i < DEPTH; i++) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        if ((CW'(i) < count) && (addr_mem[rd_ptr + AW'(i)] == 5'(r))) begin
          pending[r] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      drop_err <= 1'b0;
    end else begin
      drop_err <= accept && !in_range;
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (push && !pop) begin
        count <= count + CW'(1);
      end else if (pop && !push) begin
        count <= count - CW'(1);
      end
    end
  end

  // Storage is never reset; count alone decides which slots are meaningful.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr] <= in_addr;
      data_mem[wr_ptr] <= in_data;
    end
  end

endmodule

// File: tb/tb_vector_writeback_buffer.sv
// Directed self-checking bench for vector_writeback_buffer: reset, single write,
// back-pressure, same-register ordering, drop, throughput/wrap and mid-run reset.
module tb_vector_writeback_buffer;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [4:0]   in_addr = '0;
  logic [255:0] in_data = '0;
  logic         wb_stall = 1'b0;
  logic         WE3;
  logic [4:0]   A3;
  logic [255:0] WD3;
  logic [7:0]   pending;
  logic [2:0]   count;
  logic         full;
  logic         empty;
  logic         drop_err;

  int total = 0;
  int bad = 0;
  int wb_writes = 0;
  logic [255:0] rf [8];

  vector_writeback_buffer #(.NUM_REGS(8), .REG_WIDTH(256), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_addr(in_addr), .in_data(in_data), .wb_stall(wb_stall),
    .WE3(WE3), .A3(A3), .WD3(WD3), .pending(pending), .count(count),
    .full(full), .empty(empty), .drop_err(drop_err)
  );

  always #5 clk = ~clk;

  // Register-file model fed by write port 3.
  always @(posedge clk) begin
    if (WE3) begin
      rf[A3[2:0]] <= WD3;
      wb_writes <= wb_writes + 1;
    end
  end

  task automatic applyStimulus(input logic v, input logic [4:0] a,
                               input logic [255:0] d, input logic s);
    @(negedge clk);
    in_valid = v;
    in_addr  = a;
    in_data  = d;
    wb_stall = s;
    #1;
  endtask

  task automatic test_reset();
    #1 rst = 1'b0;
    #2;
    total++; if (count !== 3'd0) begin bad++; $display("[TB] FAIL reset_count got %0d want 0", count); end
    total++; if (empty !== 1'b1) begin bad++; $display("[TB] FAIL reset_empty got %0b want 1", empty); end
    total++; if (full !== 1'b0) begin bad++; $display("[TB] FAIL reset_full got %0b want 0", full); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_in_ready got %0b want 1", in_ready); end
    total++; if (WE3 !== 1'b0) begin bad++; $display("[TB] FAIL reset_we3 got %0b want 0", WE3); end
    total++; if (pending !== 8'h00) begin bad++; $display("[TB] FAIL reset_pending got %0h want 0", pending); end
    total++; if (A3 !== 5'd0) begin bad++; $display("[TB] FAIL reset_a3 got %0d want 0", A3); end
    total++; if (WD3 !== 256'd0) begin bad++; $display("[TB] FAIL reset_wd3 got %0h want 0", WD3); end
    total++; if (drop_err !== 1'b0) begin bad++; $display("[TB] FAIL reset_drop_err got %0b want 0", drop_err); end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_single();
    logic [255:0] d;
    d = {8{32'hAAAABEEF}};
    applyStimulus(1'b1, 5'd3, d, 1'b0);
    applyStimulus(1'b0, 5'd0, '0, 1'b0);
    total++; if (WE3 !== 1'b1) begin bad++; $display("[TB] FAIL single_we3 got %0b want 1", WE3); end
    total++; if (A3 !== 5'd3) begin bad++; $display("[TB] FAIL single_a3 got %0d want 3", A3); end
    total++; if (WD3 !== d) begin bad++; $display("[TB] FAIL single_wd3 got %0h want %0h", WD3, d); end
    total++; if (pending !== 8'h08) begin bad++; $display("[TB] FAIL single_pending got %0h want 08", pending); end
    applyStimulus(1'b0, 5'd0, '0, 1'b0);
    total++; if (empty !== 1'b1) begin bad++; $display("[TB] FAIL single_empty got %0b want 1", empty); end
    total++; if (pending !== 8'h00) begin bad++; $display("[TB] FAIL single_pending_clr got %0h want 0", pending); end
    total++; if (WE3 !== 1'b0) begin bad++; $display("[TB] FAIL single_we3_off got %0b want 0", WE3); end
    total++; if (rf[3] !== d) begin bad++; $display("[TB] FAIL single_rf3 got %0h want %0h", rf[3], d); end
  endtask

  task automatic test_backpressure();
    logic [4:0] bp [4];
    logic [31:0] w;
    int start;
    bp = '{5'd1, 5'd2, 5'd5, 5'd7};
    start = wb_writes;
    for (int i = 0; i < 4; i++) begin
      w = 32'hB000_0000 + 32'(i);
      applyStimulus(1'b1, bp[i], {8{w}}, 1'b1);
    end
    applyStimulus(1'b1, 5'd4, {8{32'hDEADDEAD}}, 1'b1);
    total++; if (full !== 1'b1) begin bad++; $display("[TB] FAIL bp_full got %0b want 1", full); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("[TB] FAIL bp_in_ready got %0b want 0", in_ready); end
    total++; if (count !== 3'd4) begin bad++; $display("[TB] FAIL bp_count got %0d want 4", count); end
    total++; if (pending !== 8'hA6) begin bad++; $display("[TB] FAIL bp_pending got %0h want a6", pending); end
    total++; if (WE3 !== 1'b0) begin bad++; $display("[TB] FAIL bp_we3_stalled got %0b want 0", WE3); end
    total++; if (A3 !== 5'd1) begin bad++; $display("[TB] FAIL bp_a3_stalled got %0d want 1", A3); end
    applyStimulus(1'b0, 5'd0, '0, 1'b0);
    total++; if (count !== 3'd4) begin bad++; $display("[TB] FAIL bp_fifth_rejected got %0d want 4", count); end
    for (int i = 0; i < 4; i++) begin
      if (i > 0) applyStimulus(1'b0, 5'd0, '0, 1'b0);
      w = 32'hB000_0000 + 32'(i);
      total++; if (WE3 !== 1'b1) begin bad++; $display("[TB] FAIL bp_drain_we3 got %0b want 1", WE3); end
      total++; if (A3 !== bp[i]) begin bad++; $display("[TB] FAIL bp_drain_a3 got %0d want %0d", A3, bp[i]); end
      total++; if (WD3 !== {8{w}}) begin bad++; $display("[TB] FAIL bp_drain_wd3 got %0h want %0h", WD3, {8{w}}); end
    end
    applyStimulus(1'b0, 5'd0, '0, 1'b0);
    total++; if (empty !== 1'b1) begin bad++; $display("[TB] FAIL bp_empty got %0b want 1", empty); end
    total++; if (wb_writes - start !== 4) begin bad++; $display("[TB] FAIL bp_writes got %0d want 4", wb_writes - start); end
  endtask

  task automatic test_same_reg();
    logic [255:0] d0;
    logic [255:0] d1;
    d0 = {8{32'hCAFEBABE}};
    d1 = {8{32'h12345678}};
    applyStimulus(1'b1, 5'd7, d0, 1'b1);
    applyStimulus(1'b1, 5'd7, d1, 1'b1);
    applyStimulus(1'b0, 5'd0, '0, 1'b1);
    total++; if (count !== 3'd2) begin bad++; $display("[TB] FAIL same_count got %0d want 2", count); end
    total++; if (pending !== 8'h80) begin bad++; $display("[TB] FAIL same_pending got %0h want 80", pending); end
    applyStimulus(1'b0, 5'd0, '0, 1'b0);
    total++; if (WD3 !== d0) begin bad++; $display("[TB] FAIL same_first_wd3 got %0h want %0h", WD3, d0); end
    applyStimulus(1'b0, 5'd0, '0, 1'b0);
    total++; if (pending[7] !== 1'b1) begin bad++; $display("[TB] FAIL same_pending_hold got %0b want 1", pending[7]); end
    total++; if (WD3 !== d1) begin bad++; $display("[TB] FAIL same_second_wd3 got %0h want %0h", WD3, d1); end
    applyStimulus(1'b0, 5'd0, '0, 1'b0);
    total++; if (pending !== 8'h00) begin bad++; $display("[TB] FAIL same_pending_clr got %0h want 0", pending); end
    total++; if (rf[7] !== d1) begin bad++; $display("[TB] FAIL same_rf7 got %0h want %0h", rf[7], d1); end
  endtask

  task automatic test_out_of_range();
    int start;
    start = wb_writes;
    applyStimulus(1'b1, 5'd9, {8{32'h99999999}}, 1'b0);
    total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL oor_in_ready got %0b want 1", in_ready); end
    applyStimulus(1'b0, 5'd0, '0, 1'b0);
    total++; if (drop_err !== 1'b1) begin bad++; $display("[TB] FAIL oor_drop_err got %0b want 1", drop_err); end
    total++; if (count !== 3'd0) begin bad++; $display("[TB] FAIL oor_count got %0d want 0", count); end
    total++; if (WE3 !== 1'b0) begin bad++; $display("[TB] FAIL oor_we3 got %0b want 0", WE3); end
    applyStimulus(1'b0, 5'd0, '0, 1'b0);
    total++; if (drop_err !== 1'b0) begin bad++; $display("[TB] FAIL oor_drop_pulse got %0b want 0", drop_err); end
    total++; if (wb_writes !== start) begin bad++; $display("[TB] FAIL oor_writes got %0d want %0d", wb_writes, start); end
  endtask

  task automatic test_back_to_back();
    int start;
    logic [31:0] w;
    logic [31:0] wp;
    start = wb_writes;
    for (int k = 0; k < 10; k++) begin
      w = 32'h5000_0000 + 32'(k);
      wp = 32'h5000_0000 + 32'(k - 1);
      applyStimulus(1'b1, 5'(k % 8), {8{w}}, 1'b0);
      total++; if (int'(count) > 1) begin bad++; $display("[TB] FAIL b2b_count got %0d want <=1", count); end
      if (k > 0) begin
        total++; if (A3 !== 5'((k - 1) % 8) || WE3 !== 1'b1) begin bad++; $display("[TB] FAIL b2b_a3 got %0d/%0b want %0d/1", A3, WE3, (k - 1) % 8); end
        total++; if (WD3 !== {8{wp}}) begin bad++; $display("[TB] FAIL b2b_wd3 got %0h want %0h", WD3, {8{wp}}); end
      end
    end
    applyStimulus(1'b0, 5'd0, '0, 1'b0);
    total++; if (A3 !== 5'd1) begin bad++; $display("[TB] FAIL b2b_last_a3 got %0d want 1", A3); end
    applyStimulus(1'b0, 5'd0, '0, 1'b0);
    total++; if (empty !== 1'b1) begin bad++; $display("[TB] FAIL b2b_empty got %0b want 1", empty); end
    total++; if (wb_writes - start !== 10) begin bad++; $display("[TB] FAIL b2b_writes got %0d want 10", wb_writes - start); end
  endtask

  task automatic test_reset_mid();
    int start;
    logic [255:0] d;
    d = {8{32'h0F0F1234}};
    applyStimulus(1'b1, 5'd0, {8{32'h11111111}}, 1'b1);
    applyStimulus(1'b1, 5'd4, {8{32'h44444444}}, 1'b1);
    applyStimulus(1'b1, 5'd6, {8{32'h66666666}}, 1'b1);
    applyStimulus(1'b0, 5'd0, '0, 1'b1);
    total++; if (count !== 3'd3) begin bad++; $display("[TB] FAIL mid_count_pre got %0d want 3", count); end
    total++; if (pending !== 8'h51) begin bad++; $display("[TB] FAIL mid_pending_pre got %0h want 51", pending); end
    #2 rst = 1'b0;
    wb_stall = 1'b0;
    #1;
    total++; if (count !== 3'd0) begin bad++; $display("[TB] FAIL mid_count got %0d want 0", count); end
    total++; if (WE3 !== 1'b0) begin bad++; $display("[TB] FAIL mid_we3 got %0b want 0", WE3); end
    total++; if (pending !== 8'h00) begin bad++; $display("[TB] FAIL mid_pending got %0h want 0", pending); end
    total++; if (empty !== 1'b1) begin bad++; $display("[TB] FAIL mid_empty got %0b want 1", empty); end
    start = wb_writes;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b1;
    in_addr = 5'd2;
    in_data = d;
    wb_stall = 1'b1;
    applyStimulus(1'b0, 5'd0, '0, 1'b1);
    total++; if (count !== 3'd1) begin bad++; $display("[TB] FAIL mid_first_push got %0d want 1", count); end
    total++; if (A3 !== 5'd2) begin bad++; $display("[TB] FAIL mid_first_a3 got %0d want 2", A3); end
    total++; if (wb_writes !== start) begin bad++; $display("[TB] FAIL mid_no_stale_writes got %0d want %0d", wb_writes, start); end
    applyStimulus(1'b0, 5'd0, '0, 1'b0);
    applyStimulus(1'b0, 5'd0, '0, 1'b0);
    total++; if (wb_writes - start !== 1) begin bad++; $display("[TB] FAIL mid_writes got %0d want 1", wb_writes - start); end
    total++; if (rf[2] !== d) begin bad++; $display("[TB] FAIL mid_rf2 got %0h want %0h", rf[2], d); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_same_reg();
    test_out_of_range();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vector_writeback_buffer.md
VECTOR_WRITEBACK_BUFFER -- requirements
Module: vector_writeback_buffer

Interface
REQ-001: The block SHALL have the parameter NUM_REGS, default 8, giving the number of vector registers in the downstream register file.
REQ-002: The block SHALL have the parameter REG_WIDTH, default 256, giving the vector register width in bits.
REQ-003: The block SHALL have the parameter DEPTH, default 4, giving the number of buffer entries (power of two, at least 2).
REQ-004: The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005: The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-006: The block SHALL have port in_valid, input, 1 bit: the producer offers a result.
REQ-007: The block SHALL have port in_ready, output, 1 bit: the buffer can accept a result this cycle.
REQ-008: The block SHALL have port in_addr, input, 5 bits: the destination register index.
REQ-009: The block SHALL have port in_data, input, REG_WIDTH bits: the result data.
REQ-010: The block SHALL have port wb_stall, input, 1 bit: the register-file write port is unavailable this cycle.
REQ-011: The block SHALL have port WE3, output, 1 bit: register-file write enable.
REQ-012: The block SHALL have port A3, output, 5 bits: register-file write address.
REQ-013: The block SHALL have port WD3, output, REG_WIDTH bits: register-file write data.
REQ-014: The block SHALL have port pending, output, NUM_REGS bits: bit i is high while any buffered entry targets register i.
REQ-015: The block SHALL have port count, output, clog2(DEPTH)+1 bits: the number of occupied entries.
REQ-016: The block SHALL have port full, output, 1 bit: high when count equals DEPTH.
REQ-017: The block SHALL have port empty, output, 1 bit: high when count equals 0.
REQ-018: The block SHALL have port drop_err, output, 1 bit: a one-cycle pulse flagging a discarded out-of-range write.

Function
REQ-019: The block SHALL be an in-order FIFO of {addr, data} entries placed between the result producer and register-file write port 3.
REQ-020: The block SHALL drive in_ready = !full combinationally, with no same-cycle bypass when full.
REQ-021: The block SHALL push on a rising edge where in_valid && in_ready && in_addr < NUM_REGS, storing the entry at the write pointer.
REQ-022: On a handshake with in_addr >= NUM_REGS, the block SHALL accept the transfer but not store it, and SHALL register drop_err high for exactly the following cycle.
REQ-023: The block SHALL drive WE3 = !empty && !wb_stall combinationally, with A3 and WD3 equal to the head entry whenever the block is not empty.
REQ-024: When empty, the block SHALL drive A3 = 0 and WD3 = 0.
REQ-025: The block SHALL pop the head entry on every rising edge where WE3 is high.
REQ-026: Latency SHALL be: an entry pushed into an empty buffer at edge N drives WE3 during cycle N..N+1 and is written and popped at edge N+1, provided wb_stall is low.
REQ-027: Simultaneous push and pop SHALL leave count unchanged, and both pointers SHALL advance.
REQ-028: Read and write pointers SHALL wrap modulo DEPTH.
REQ-029: Count SHALL never exceed DEPTH and never go below 0.
REQ-030: Pending SHALL be the OR of onehot(addr) over all valid entries and SHALL be combinational from the stored state.
REQ-031: Pending bit i SHALL remain high until the last buffered entry targeting register i is popped.
REQ-032: Multiple entries to the same register SHALL drain in arrival order, so the last-pushed data wins in the register file.
REQ-033: While wb_stall is held high, the block SHALL keep WE3 low and SHALL keep the head entry, A3 and WD3 stable.

Reset
REQ-034: On rst low, the block SHALL immediately clear the pointers, count and drop_err.
REQ-035: On rst low, the block SHALL immediately force WE3 = 0, pending = 0, empty = 1, full = 0, in_ready = 1, A3 = 0 and WD3 = 0.
REQ-036: Entry storage contents after reset SHALL be don't-care, with no reset of the data array required.
REQ-037: Reset asserted mid-operation SHALL discard all buffered entries, and no WE3 pulse for a discarded entry SHALL occur after rst deasserts.
REQ-038: The first push SHALL be accepted on the first rising edge after rst is released.

Verification
REQ-039: Single write: push addr 3, data {8{32'hAAAABEEF}} with wb_stall = 0 -> on the next cycle WE3 = 1, A3 = 3, WD3 = that data and pending = 8'h08; the cycle after, empty = 1 and pending = 0.
REQ-040: Back-pressure: hold wb_stall = 1 and push addrs 1, 2, 5, 7 -> full = 1, in_ready = 0, count = 4 and pending = 8'hA6; a fifth in_valid is not accepted; release wb_stall -> WE3 addresses 1, 2, 5, 7 on four consecutive cycles.
REQ-041: Same-register ordering: with the block stalled, push addr 7 data {8{32'hCAFEBABE}} then addr 7 data {8{32'h12345678}} -> pending[7] stays high until the second pop, and the register file finally reads 32'h12345678 lanes.
REQ-042: Out-of-range: push addr 9 -> the handshake completes, drop_err is high for one cycle, count is unchanged and WE3 stays 0.
REQ-043: Wrap and throughput: 10 back-to-back pushes with wb_stall = 0 -> count stays at or below 1 and 10 in-order WE3 pulses occur, with pointers wrapping past DEPTH.
REQ-044: Reset mid-operation: with 3 entries buffered, assert rst asynchronously between edges -> count = 0, WE3 = 0 and pending = 0 immediately, and no writes occur after release.
